// File: rtl/ddc_retune_ctrl_if.sv
// Command handshake and settings-bus signals between the host side and
// ddc_retune_ctrl. The host drives commands (master) and the controller drives the settings bus (slave).
interface ddc_retune_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_phase_inc;
    logic [17:0] cmd_scale;
    logic [9:0]  cmd_decim;
    logic [1:0]  cmd_mode;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;

    modport master (
        output cmd_valid, cmd_phase_inc, cmd_scale, cmd_decim, cmd_mode,
        input  cmd_ready, set_stb, set_addr, set_data
    );

    modport slave (
        input  cmd_valid, cmd_phase_inc, cmd_scale, cmd_decim, cmd_mode,
        output cmd_ready, set_stb, set_addr, set_data
    );
endinterface

// File: rtl/ddc_retune_ctrl.sv
// Retune sequencer for one DDC chain: stop, drain, write settings, clear, restore run.
// Optional macro DDC_RETUNE_SKIP_UNCHANGED_EN skips writes whose value matches the last one written.
//
// state | meaning
// IDLE  | run follows run_req, waiting for a command
// DRAIN | run held low while the pipeline empties
// WRITE | one settings-bus strobe per cycle for each pending register
// CLEAR | one-cycle clr pulse, run still low
module ddc_retune_ctrl #(
    parameter int BASE          = 0,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    ddc_retune_ctrl_if.slave  bus,
    input  logic              run_req,
    output logic              run,
    output logic              clr,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, DRAIN, WRITE, CLEAR} state_t;

    localparam logic [7:0]       BASE_A    = 8'(BASE);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam bit               DRAIN_EN  = (SETTLE_CYCLES > 0);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [3:0]        pend, pend_n;
    logic [31:0]       phase_q, phase_n;
    logic [17:0]       scale_q, scale_n;
    logic [9:0]        decim_q, decim_n;
    logic [1:0]        mode_q, mode_n;
    logic              run_n, clr_n, busy_n;
    logic              stb_q, stb_n;
    logic [7:0]        addr_q, addr_n;
    logic [31:0]       data_q, data_n;

    logic              accept;
    logic              go_write;
    logic [3:0]        wmask;
    logic [3:0]        acc_mask;
    logic [1:0]        sel;
    logic [31:0]       val [4];

    assign bus.cmd_ready = (state == IDLE) & ~rst;
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign bus.set_stb   = stb_q;
    assign bus.set_addr  = addr_q;
    assign bus.set_data  = data_q;

    // In IDLE the write values come straight from the command so a
    // no-drain accept can strobe on the very next cycle.
    always_comb begin
        if (state == IDLE) begin
            val[0] = bus.cmd_phase_inc;
            val[1] = {14'b0, bus.cmd_scale};
            val[2] = {22'b0, bus.cmd_decim};
            val[3] = {30'b0, bus.cmd_mode};
        end else begin
            val[0] = phase_q;
            val[1] = {14'b0, scale_q};
            val[2] = {22'b0, decim_q};
            val[3] = {30'b0, mode_q};
        end
    end

`ifdef DDC_RETUNE_SKIP_UNCHANGED_EN
    logic [31:0] shadow [4];
    logic        shadow_vld;

    always_comb begin
        acc_mask = 4'b0;
        for (int i = 0; i < 4; i++) begin
            acc_mask[i] = ~shadow_vld | (val[i] != shadow[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
            end
            shadow_vld <= 1'b0;
        end else begin
            if (stb_n) begin
                shadow[sel] <= data_n;
            end
            if (state_n == CLEAR && state != CLEAR) begin
                shadow_vld <= 1'b1;
            end
        end
    end
`else
    assign acc_mask = 4'b1111;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pend_n   = pend;
        phase_n  = phase_q;
        scale_n  = scale_q;
        decim_n  = decim_q;
        mode_n   = mode_q;
        stb_n    = 1'b0;
        addr_n   = addr_q;
        data_n   = data_q;
        go_write = 1'b0;
        wmask    = pend;
        sel      = 2'd0;

        case (state)
            IDLE: begin
                if (accept) begin
                    phase_n = bus.cmd_phase_inc;
                    scale_n = bus.cmd_scale;
                    decim_n = bus.cmd_decim;
                    mode_n  = bus.cmd_mode;
                    if (run && DRAIN_EN) begin
                        state_n = DRAIN;
                        cnt_n   = SETTLE_LD;
                        pend_n  = acc_mask;
                    end else begin
                        go_write = 1'b1;
                        wmask    = acc_mask;
                    end
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    go_write = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WRITE: go_write = 1'b1;
            CLEAR: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Lowest pending register goes next, keeping the fixed write order.
        if (go_write) begin
            if (wmask != 4'b0) begin
                for (int i = 3; i >= 0; i--) begin
                    if (wmask[i]) sel = 2'(i);
                end
                state_n = WRITE;
                stb_n   = 1'b1;
                addr_n  = BASE_A + {6'b0, sel};
                data_n  = val[sel];
                pend_n  = wmask & ~(4'b1 << sel);
            end else begin
                state_n = CLEAR;
                pend_n  = 4'b0;
            end
        end

        run_n  = (state == IDLE && state_n == IDLE) ? run_req : 1'b0;
        clr_n  = (state_n == CLEAR);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= 4'b0;
            phase_q <= '0;
            scale_q <= '0;
            decim_q <= '0;
            mode_q  <= '0;
            run     <= 1'b0;
            clr     <= 1'b0;
            busy    <= 1'b0;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend    <= pend_n;
            phase_q <= phase_n;
            scale_q <= scale_n;
            decim_q <= decim_n;
            mode_q  <= mode_n;
            run     <= run_n;
            clr     <= clr_n;
            busy    <= busy_n;
            stb_q   <= stb_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
        end
    end

endmodule

// File: doc/ddc_retune_ctrl.md
Name: ddc_retune_ctrl

Overview:
Sequences safe reconfiguration of one DDC chain instance. Accepts a retune command (NCO phase increment, scale factor, decimation/halfband enables, real/swap mode) over a valid/ready handshake. It then stops the chain, lets the pipeline drain, issues the settings-bus writes in a fixed order, pulses clr, and restores run. Sits between host/radio control and the DDC settings bus and run/clr inputs; it owns those signals exclusively.

Parameters:
BASE, 0, settings address of DDC register 0; writes go to BASE+0..BASE+3
SETTLE_CYCLES, 16, clk cycles run is held low before writing (0 = no drain); 1..65535 legal
CNT_W, 16, width of drain counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cmd_valid  input  1  retune command valid
cmd_ready  output  1  controller can accept command
cmd_phase_inc  input  32  NCO phase increment
cmd_scale  input  18  output scale factor
cmd_decim  input  10  {enable_hb1, enable_hb2, cic_decim_rate[7:0]}
cmd_mode  input  2  {realmode, swap_iq}
run_req  input  1  requested run state from control
run  output  1  run to DDC chain
clr  output  1  clear pulse to DDC chain
set_stb  output  1  settings write strobe
set_addr  output  8  settings address
set_data  output  32  settings data
busy  output  1  retune in progress

Behaviour:
- Reset: state IDLE; run=0, clr=0, set_stb=0, set_addr=0, set_data=0, busy=0, cmd_ready=0 during rst; drain counter and shadow regs cleared to 0.
- All outputs registered. cmd_ready = (state==IDLE) & ~rst. Accept = cmd_valid & cmd_ready; all cmd_* latched on the accept edge.
- IDLE: run <= run_req each cycle (1-cycle latency). busy=0. On accept: busy<=1, run<=0. Next state is DRAIN if run==1 at the accept edge and SETTLE_CYCLES>0, else WRITE.
- DRAIN: run=0. Counter loads SETTLE_CYCLES-1 on entry and decrements each cycle. Exit to WRITE when the counter is 0, so DRAIN occupies exactly SETTLE_CYCLES cycles.
- WRITE: four consecutive cycles with set_stb=1, in this order:
  - BASE+0 data=phase_inc
  - BASE+1 data={14'b0,scale}
  - BASE+2 data={22'b0,decim}
  - BASE+3 data={30'b0,mode}
  - set_addr is 8-bit wrap of BASE+n.
- Then CLEAR: clr=1 for exactly one cycle, set_stb=0, run=0.
- Then IDLE: run follows run_req from the next cycle; busy=0 and cmd_ready=1 in the first IDLE cycle.
- Latency with run=1 at accept (accept edge T): run=0 at T+1; first set_stb at T+1+SETTLE_CYCLES; clr at T+5+SETTLE_CYCLES; cmd_ready at T+6+SETTLE_CYCLES.
- Latency with run=0 at accept: first set_stb at T+1.
- run_req changes during DRAIN/WRITE/CLEAR are ignored; the sampled value is applied once back in IDLE.
- cmd_valid held high continuously: one command per sequence, never two accepts without an IDLE cycle between.
- set_data and set_addr hold their last value when set_stb=0.
- rst mid-sequence: immediate return to reset values; any partial writes already issued stand, no further strobes.
- Shadow regs are updated with each written value (used by the optional feature).

Optional Feature:
DDC_RETUNE_SKIP_UNCHANGED_EN.
- Defined: in WRITE, a register whose new value equals its shadow is skipped; no strobe, no cycle consumed. Shadows are invalid after reset, so the first command writes all four. If all four match, the WRITE phase takes 0 cycles and CLEAR follows directly. DRAIN and CLEAR still occur.
- Undefined: all four writes are always issued; shadows are unused and may be optimised away.

Test Plan:
- Reset, then run_req=1 with no command → run=1 one cycle after run_req; clr, set_stb, busy stay 0; cmd_ready=1.
- run=1, SETTLE_CYCLES=16, BASE=8, command phase_inc=0x12345678, scale=0x2ABCD, decim=0x304, mode=2'b10 → run falls at T+1; strobes at T+17..T+20 with addr 8,9,10,11 and data 0x12345678, 0x0002ABCD, 0x00000304, 0x00000002; clr at T+21; run=1 at T+23.
- run_req=0 at accept → no DRAIN; first strobe at T+1; run stays 0 afterwards.
- cmd_valid held high with back-to-back commands → second accept only after cmd_ready returns; no overlapping strobes.
- rst asserted on the second WRITE cycle → next cycle all outputs at reset values; no further set_stb.
- With DDC_RETUNE_SKIP_UNCHANGED_EN, repeat an identical command with only phase_inc changed → exactly one strobe (addr BASE+0), then clr.
